// File: rtl/alu_sequencer.sv
// Sequential front end for the combinational 32-bit ALU: accepts one request at a time,
// holds the operands on the ALU for a programmable settle time, then returns the captured result.
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_op1,
    input  logic [31:0]      req_op2,
    input  logic [2:0]       req_operator,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_op1,
    output logic [31:0]      alu_op2,
    output logic [2:0]       alu_operator,
    input  logic [31:0]      alu_result,
    input  logic             alu_is_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_result,
    output logic             resp_zero,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        RESP
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [3:0]        settle_cnt;
    logic [3:0]        settle_cnt_next;
    logic              armed;
    logic              accept;
    logic              capture;
    logic [TAG_W-1:0]  tag_q;

    // armed keeps req_ready low while reset is asserted even though the FSM already sits in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            armed      <= 1'b0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
            armed      <= 1'b1;
        end
    end

    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        accept          = 1'b0;
        capture         = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && armed) begin
                    accept          = 1'b1;
                    settle_cnt_next = SETTLE_INIT;
                    state_next      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_next = CAPTURE;
                end else begin
                    settle_cnt_next = settle_cnt - 4'd1;
                end
            end
            CAPTURE: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ALU-drive registers hold their last values in IDLE; response registers hold through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op1      <= 32'd0;
            alu_op2      <= 32'd0;
            alu_operator <= 3'd0;
            tag_q        <= '0;
            resp_result  <= 32'd0;
            resp_zero    <= 1'b0;
            resp_tag     <= '0;
        end else begin
            if (accept) begin
                alu_op1      <= req_op1;
                alu_op2      <= req_op2;
                alu_operator <= req_operator;
                tag_q        <= req_tag;
            end
            if (capture) begin
                resp_result <= alu_result;
                resp_zero   <= alu_is_zero;
                resp_tag    <= tag_q;
            end
        end
    end

    assign req_ready  = armed && (state == IDLE);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with an adder stub ALU; expected responses go through a scoreboard queue.
module tb_alu_sequencer;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic [2:0]  req_operator;
    logic [3:0]  req_tag;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [2:0]  alu_operator;
    logic [31:0] alu_result;
    logic        alu_is_zero;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic [3:0]  resp_tag;
    logic        busy;

    logic        d4_req_valid;
    logic        d4_req_ready;
    logic [31:0] d4_req_op1;
    logic [31:0] d4_req_op2;
    logic [2:0]  d4_req_operator;
    logic [3:0]  d4_req_tag;
    logic [31:0] d4_alu_op1;
    logic [31:0] d4_alu_op2;
    logic [2:0]  d4_alu_operator;
    logic [31:0] d4_alu_result;
    logic        d4_alu_is_zero;
    logic        d4_resp_valid;
    logic        d4_resp_ready;
    logic [31:0] d4_resp_result;
    logic        d4_resp_zero;
    logic [3:0]  d4_resp_tag;
    logic        d4_busy;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    // stub ALU: sum of the operands, zero flag on the sum
    assign alu_result     = alu_op1 + alu_op2;
    assign alu_is_zero    = (alu_result == 32'd0);
    assign d4_alu_result  = d4_alu_op1 + d4_alu_op2;
    assign d4_alu_is_zero = (d4_alu_result == 32'd0);

    alu_sequencer #(.SETTLE_CYCLES(1), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2),
        .req_operator(req_operator), .req_tag(req_tag),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_operator(alu_operator),
        .alu_result(alu_result), .alu_is_zero(alu_is_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_tag(resp_tag),
        .busy(busy)
    );

    alu_sequencer #(.SETTLE_CYCLES(4), .TAG_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d4_req_valid), .req_ready(d4_req_ready),
        .req_op1(d4_req_op1), .req_op2(d4_req_op2),
        .req_operator(d4_req_operator), .req_tag(d4_req_tag),
        .alu_op1(d4_alu_op1), .alu_op2(d4_alu_op2), .alu_operator(d4_alu_operator),
        .alu_result(d4_alu_result), .alu_is_zero(d4_alu_is_zero),
        .resp_valid(d4_resp_valid), .resp_ready(d4_resp_ready),
        .resp_result(d4_resp_result), .resp_zero(d4_resp_zero), .resp_tag(d4_resp_tag),
        .busy(d4_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic driveReq(input logic [31:0] op1, input logic [31:0] op2,
                            input logic [2:0] opr, input logic [3:0] tag);
        exp_t e;
        req_valid    = 1'b1;
        req_op1      = op1;
        req_op2      = op2;
        req_operator = opr;
        req_tag      = tag;
        e.result     = op1 + op2;
        e.zero       = ((op1 + op2) == 32'd0);
        e.tag        = tag;
        sbq.push_back(e);
    endtask

    // offers a request and returns just after the accept edge
    task automatic applyStimulus(input logic [31:0] op1, input logic [31:0] op2,
                                 input logic [2:0] opr, input logic [3:0] tag);
        int  guard;
        bit  accepted;
        guard    = 0;
        accepted = 1'b0;
        driveReq(op1, op2, opr, tag);
        while (!accepted && guard < 50) begin
            if (req_ready) accepted = 1'b1;
            step();
            guard++;
        end
        req_valid = 1'b0;
        checkOutput("accept_seen", 32'(accepted), 32'd1);
    endtask

    task automatic waitRespValid(input string name, input int maxCycles, output int waited);
        waited = 0;
        while (!resp_valid && waited < maxCycles) begin
            step();
            waited++;
        end
        checkOutput({name, "_valid"}, 32'(resp_valid), 32'd1);
    endtask

    task automatic checkResp(input string name);
        exp_t e;
        checkOutput({name, "_queue"}, 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput({name, "_result"}, resp_result, e.result);
            checkOutput({name, "_zero"}, 32'(resp_zero), 32'(e.zero));
            checkOutput({name, "_tag"}, 32'(resp_tag), 32'(e.tag));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int   waited;
        bit   done;
        int   guard;
        logic [31:0] a;
        logic [31:0] b;

        rst_n = 1'b0;
        req_valid = 1'b0; req_op1 = '0; req_op2 = '0; req_operator = '0; req_tag = '0;
        resp_ready = 1'b0;
        d4_req_valid = 1'b0; d4_req_op1 = '0; d4_req_op2 = '0; d4_req_operator = '0;
        d4_req_tag = '0; d4_resp_ready = 1'b1;

        // reset values
        #12;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_alu_op1", alu_op1, 32'd0);
        checkOutput("rst_alu_operator", 32'(alu_operator), 32'd0);
        checkOutput("rst_resp_result", resp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_before_edge", 32'(req_ready), 32'd0);
        step();
        checkOutput("ready_after_edge", 32'(req_ready), 32'd1);

        // basic request
        resp_ready = 1'b1;
        applyStimulus(32'd16, 32'd16, 3'b001, 4'd3);
        checkOutput("basic_settle_operator", 32'(alu_operator), 32'd1);
        checkOutput("basic_settle_op1", alu_op1, 32'd16);
        checkOutput("basic_settle_ready", 32'(req_ready), 32'd0);
        checkOutput("basic_settle_busy", 32'(busy), 32'd1);
        waitRespValid("basic", 10, waited);
        checkOutput("basic_latency", 32'(waited), 32'd2);
        checkResp("basic");
        step();
        checkOutput("basic_after_valid", 32'(resp_valid), 32'd0);
        checkOutput("basic_after_ready", 32'(req_ready), 32'd1);

        // zero flag and wrap-around
        applyStimulus(32'hFFFF_FFFF, 32'd1, 3'b010, 4'd5);
        waitRespValid("wrap", 10, waited);
        checkResp("wrap");
        step();

        // back-pressure with a second request pending
        resp_ready = 1'b0;
        applyStimulus(32'd100, 32'd23, 3'b100, 4'd6);
        waitRespValid("bp_a", 10, waited);
        driveReq(32'd7, 32'd8, 3'b011, 4'd7);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("bp_hold_valid", 32'(resp_valid), 32'd1);
            checkOutput("bp_hold_result", resp_result, 32'd123);
            checkOutput("bp_hold_tag", 32'(resp_tag), 32'd6);
            checkOutput("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        checkResp("bp_a");
        step();
        checkOutput("bp_idle_busy", 32'(busy), 32'd0);
        checkOutput("bp_idle_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        checkOutput("bp_b_accepted", 32'(busy), 32'd1);
        checkOutput("bp_b_op1", alu_op1, 32'd7);
        waitRespValid("bp_b", 10, waited);
        checkResp("bp_b");
        step();

        // settle time of four cycles on the second instance
        d4_req_valid = 1'b1; d4_req_op1 = 32'd1000; d4_req_op2 = 32'd234;
        d4_req_operator = 3'b111; d4_req_tag = 4'd2;
        checkOutput("s4_ready", 32'(d4_req_ready), 32'd1);
        step();
        d4_req_valid = 1'b0;
        d4_req_op1 = 32'hDEAD_BEEF; d4_req_op2 = 32'h1234_5678;
        for (int k = 0; k < 5; k++) begin
            checkOutput("s4_no_valid", 32'(d4_resp_valid), 32'd0);
            checkOutput("s4_op1_stable", d4_alu_op1, 32'd1000);
            checkOutput("s4_op2_stable", d4_alu_op2, 32'd234);
            step();
        end
        checkOutput("s4_valid", 32'(d4_resp_valid), 32'd1);
        checkOutput("s4_result", d4_resp_result, 32'd1234);
        checkOutput("s4_tag", 32'(d4_resp_tag), 32'd2);
        step();
        checkOutput("s4_done", 32'(d4_resp_valid), 32'd0);

        // reset while settling
        applyStimulus(32'd9, 32'd9, 3'b000, 4'd8);
        void'(sbq.pop_back());
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_alu_op1", alu_op1, 32'd0);
        checkOutput("mid_rst_alu_op2", alu_op2, 32'd0);
        checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
        checkOutput("mid_rst_resp_tag", 32'(resp_tag), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput("post_rst_no_valid", 32'(resp_valid), 32'd0);
        end
        applyStimulus(32'd5, 32'd7, 3'b000, 4'd9);
        waitRespValid("post_rst", 10, waited);
        checkResp("post_rst");
        step();

        // stream of eight requests with random consumer back-pressure
        for (int t = 0; t < 8; t++) begin
            a = $urandom;
            b = (t == 5) ? (32'd0 - a) : $urandom;
            applyStimulus(a, b, 3'($urandom_range(0, 7)), 4'(t));
            done  = 1'b0;
            guard = 0;
            while (!done && guard < 100) begin
                resp_ready = 1'($urandom_range(0, 1));
                if (resp_valid && resp_ready) begin
                    checkResp("stream");
                    done = 1'b1;
                end
                step();
                guard++;
            end
            checkOutput("stream_done", 32'(done), 32'd1);
        end
        checkOutput("queue_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
